// File: rtl/param_register_file.sv
// Parameterised 2-read/1-write register file with a sequential clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module param_register_file #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] reg1,
   input  logic [ADDR_W-1:0] reg2,
   input  logic [ADDR_W-1:0] write_code,
   input  logic              w_flag,
   input  logic [DATA_W-1:0] w_data,
   input  logic              clr_req,
   output logic [DATA_W-1:0] read1,
   output logic [DATA_W-1:0] read2,
   output logic              busy,
   output logic              clr_done
);

   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] counter, next_counter;
   logic              next_done;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              user_wr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_val;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         counter  <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= next_state;
         counter  <= next_counter;
         clr_done <= next_done;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      next_state   = state;
      next_counter = counter;
      next_done    = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               next_state   = CLEAR;
               next_counter = '0;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (counter == LAST) begin
               next_state = IDLE;
               next_done  = 1'b1;
            end else begin
               next_counter = counter + ADDR_W'(1);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The sweep owns the write port while busy; user writes to a hardwired
   // register 0 are dropped here so the bypass path sees the same decision.
   always_comb begin
      user_wr = w_flag && !busy && !((ZERO_REG != 0) && (write_code == '0));
      wr_en   = busy || user_wr;
      wr_addr = busy ? counter : write_code;
      wr_val  = busy ? '0 : w_data;
   end

   // NOTE: the whole array is cleared by reset, which forces flop storage
   // rather than a RAM macro; the contents must be zero after reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_val;
      end
   end

   always_comb begin
      read1 = mem[reg1];
      read2 = mem[reg2];
`ifdef RF_BYPASS_EN
      if (user_wr && (write_code == reg1)) read1 = w_data;
      if (user_wr && (write_code == reg2)) read2 = w_data;
`else
`endif
      if ((ZERO_REG != 0) && (reg1 == '0)) read1 = '0;
      if ((ZERO_REG != 0) && (reg2 == '0)) read2 = '0;
   end

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file: default instance plus
// a ZERO_REG=1, DATA_W=32, ADDR_W=3 instance; expectations follow RF_BYPASS_EN.
module tb_param_register_file;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  reg1, reg2, write_code;
   logic        w_flag, clr_req;
   logic [15:0] w_data;
   logic [15:0] read1, read2;
   logic        busy, clr_done;

   logic [2:0]  z_reg1, z_reg2, z_write_code;
   logic        z_w_flag, z_clr_req;
   logic [31:0] z_w_data;
   logic [31:0] z_read1, z_read2;
   logic        z_busy, z_clr_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   param_register_file dut (
      .clk(clk), .reset_n(reset_n), .reg1(reg1), .reg2(reg2),
      .write_code(write_code), .w_flag(w_flag), .w_data(w_data),
      .clr_req(clr_req), .read1(read1), .read2(read2),
      .busy(busy), .clr_done(clr_done)
   );

   param_register_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dut_z (
      .clk(clk), .reset_n(reset_n), .reg1(z_reg1), .reg2(z_reg2),
      .write_code(z_write_code), .w_flag(z_w_flag), .w_data(z_w_data),
      .clr_req(z_clr_req), .read1(z_read1), .read2(z_read2),
      .busy(z_busy), .clr_done(z_clr_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [3:0] addr, input logic [15:0] data);
      @(negedge clk);
      w_flag = 1'b1; write_code = addr; w_data = data;
      @(negedge clk);
      w_flag = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         reg1 = 4'(i); reg2 = 4'(15 - i);
         #1;
         check(tag, {16'h0, read1}, 32'h0);
         check(tag, {16'h0, read2}, 32'h0);
      end
   endtask

   logic [15:0] table_v [16] = '{16'h1234, 16'h0000, 16'hffff, 16'h1337,
                                 16'h4444, 16'h5555, 16'h6666, 16'h7777,
                                 16'h8888, 16'h9999, 16'haaaa, 16'hbbbb,
                                 16'hcccc, 16'h1995, 16'h1028, 16'h2014};
   logic [15:0] bypass_exp;
   logic [31:0] z_bypass_exp;
   int busy_cnt, done_cnt, done_at;

   initial begin
      reset_n = 1'b0; reg1 = '0; reg2 = '0; write_code = '0;
      w_flag = 1'b0; w_data = '0; clr_req = 1'b0;
      z_reg1 = '0; z_reg2 = '0; z_write_code = '0;
      z_w_flag = 1'b0; z_w_data = '0; z_clr_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_clr_done", {31'h0, clr_done}, 32'h0);
      check_all_zero("reset_read");

      // Fill table and read back pairs
      for (int i = 0; i < 16; i++) write_word(4'(i), table_v[i]);
      reg1 = 4'd0; reg2 = 4'd14; #1;
      check("pair_0", {16'h0, read1}, 32'h1234);
      check("pair_14", {16'h0, read2}, 32'h1028);
      reg1 = 4'd13; reg2 = 4'd3; #1;
      check("pair_13", {16'h0, read1}, 32'h1995);
      check("pair_3", {16'h0, read2}, 32'h1337);
      reg1 = 4'd2; reg2 = 4'd2; #1;
      check("same_addr_1", {16'h0, read1}, 32'hffff);
      check("same_addr_2", {16'h0, read2}, 32'hffff);

      // Write forwarding (or its absence) on address 9
`ifdef RF_BYPASS_EN
      bypass_exp = 16'hc0de;
`else
      bypass_exp = 16'h9999;
`endif
      @(negedge clk);
      reg1 = 4'd9; w_flag = 1'b1; write_code = 4'd9; w_data = 16'hc0de; #1;
      check("bypass_same_cycle", {16'h0, read1}, {16'h0, bypass_exp});
      @(negedge clk);
      w_flag = 1'b0; #1;
      check("bypass_next_cycle", {16'h0, read1}, 32'hc0de);

      // Clear sweep
      write_word(4'd5, 16'hdead);
      reg1 = 4'd5; reg2 = 4'd15;
      clr_req = 1'b1;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 0) begin
            clr_req = 1'b0; #1;
            check("sweep_pre_5", {16'h0, read1}, 32'hdead);
         end
         if (i == 8) check("sweep_pending_15", {16'h0, read2}, 32'h2014);
         if (busy) busy_cnt++;
         if (clr_done) begin done_cnt++; done_at = i; end
      end
      check("sweep_busy_len", busy_cnt, 32'd16);
      check("sweep_done_cnt", done_cnt, 32'd1);
      check("sweep_done_at", done_at, 32'd16);
      check_all_zero("sweep_read");

      // Simultaneous write+clear, then ignored write/clear while busy
      write_word(4'd15, 16'haaaa);
      reg1 = 4'd3; reg2 = 4'd15;
      @(negedge clk);
      w_flag = 1'b1; write_code = 4'd3; w_data = 16'h3333; clr_req = 1'b1;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (clr_done) done_cnt++;
         if (i == 0) begin
            w_flag = 1'b0; clr_req = 1'b0; #1;
            check("wr_and_clr_commit", {16'h0, read1}, 32'h3333);
         end
         if (i == 2) begin
            w_flag = 1'b1; write_code = 4'd15; w_data = 16'hbeef; clr_req = 1'b1;
         end
         if (i == 3) check("busy_write_ignored", {16'h0, read2}, 32'haaaa);
         if (i == 5) begin w_flag = 1'b0; clr_req = 1'b0; end
      end
      check("restart_busy_len", busy_cnt, 32'd16);
      check("restart_done_cnt", done_cnt, 32'd1);
      #1;
      check("end_read_3", {16'h0, read1}, 32'h0);
      check("end_read_15", {16'h0, read2}, 32'h0);

      // Reset mid-sweep
      write_word(4'd7, 16'h7777);
      reg1 = 4'd7;
      clr_req = 1'b1;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (clr_done) done_cnt++;
         if (i == 0) clr_req = 1'b0;
         if (i == 5) reset_n = 1'b0;
         if (i == 6) begin
            check("abort_busy", {31'h0, busy}, 32'h0);
            reset_n = 1'b1;
         end
      end
      check("abort_busy_len", busy_cnt, 32'd6);
      check("abort_no_done", done_cnt, 32'd0);
      check_all_zero("abort_read");

      // Hardwired zero register instance
`ifdef RF_BYPASS_EN
      z_bypass_exp = 32'hcafef00d;
`else
      z_bypass_exp = 32'h0;
`endif
      z_reg1 = 3'd0; z_reg2 = 3'd7;
      @(negedge clk);
      z_w_flag = 1'b1; z_write_code = 3'd0; z_w_data = 32'hcafef00d; #1;
      check("zero_no_bypass", z_read1, 32'h0);
      @(negedge clk);
      z_write_code = 3'd7; #1;
      check("zero_inst_bypass_7", z_read2, z_bypass_exp);
      @(negedge clk);
      z_w_flag = 1'b0; #1;
      check("zero_read_0", z_read1, 32'h0);
      check("zero_read_7", z_read2, 32'hcafef00d);
      check("zero_inst_busy", {31'h0, z_busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
